uart_rx_datapath: RTL and testbench

Timing and data half of the UART receiver. It runs beside the uart_fsm state machine and consumes its 3-bit status. It synchronises the serial input, generates the half-baud, baud and last-bit strobes the FSM steps on, shifts in data bits LSB-first, and presents each received byte with a one-clock valid pulse or a framing-error pulse. Downstream consumers include the MIDI byte parser.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync.sv | 31 +++
 rtl/uart_rx_datapath.sv | 128 ++++++++++++
 tb/tb_uart_rx_datapath.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: uart_fsm status encodings and
// the default frame timing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_START       = 3'd1,
        ST_START_CHECK = 3'd2,
        ST_READ        = 3'd3,
        ST_STOP        = 3'd4
    } uart_status_e;

    // 50 MHz system clock, 31250 baud MIDI line.
    localparam int unsigned BAUD_DIV_DEFAULT  = 1600;
    localparam int unsigned DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops preset
// to 1 so the line reads as idle straight out of reset.
module uart_sync (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments keep the two stages a real two-cycle delay.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_datapath.sv
// Timing and data half of the UART receiver: baud counting, strobes for the
// uart_fsm, LSB-first shifting and the byte / framing-error outputs.
module uart_rx_datapath
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = BAUD_DIV_DEFAULT,
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 ce,
    input  logic                 rx,
    input  logic [2:0]           status,
    output logic                 rx_sync,
    output logic                 hb,
    output logic                 bd,
    output logic                 lb,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic [IDX_W-1:0]     bit_idx_d, bit_idx_q;
    logic [DATA_BITS-1:0] shift_d, shift_q;
    logic [DATA_BITS-1:0] data_d, data_q;
    logic                 valid_d, valid_q;
    logic                 frame_err_d, frame_err_q;

    logic in_start, in_read, in_stop;

    uart_sync u_sync (
        .clk (clk),
        .clr (clr),
        .d   (rx),
        .q   (rx_sync)
    );

    assign in_start = (status == ST_START);
    assign in_read  = (status == ST_READ);
    assign in_stop  = (status == ST_STOP);

    // Strobes are qualified by ce so the FSM sees exactly one per counted step.
    assign hb = ~clr & ce & in_start & (cnt_q == CNT_HALF);
    assign bd = ~clr & ce & (in_read | in_stop) & (cnt_q == CNT_FULL);
    assign lb = bd & in_read & (bit_idx_q == IDX_LAST);

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (ce) begin
            case (status)
                ST_START: begin
                    cnt_d     = hb ? '0 : cnt_q + CNT_W'(1);
                    bit_idx_d = '0;
                end
                ST_START_CHECK: begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
                ST_READ: begin
                    if (bd) begin
                        cnt_d     = '0;
                        shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    bit_idx_d = '0;
                    if (bd) begin
                        cnt_d = '0;
                        if (rx_sync) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            endcase
        end
    end

    // NOTE: the shift register is reset too; clr mid-frame must not leak stale bits.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Bench for uart_rx_datapath: a behavioural uart_fsm peer per instance, serial
// frames built from random bytes, and a byte-level expectation model.
module tb_uart_rx_datapath;
    import uart_pkg::*;

    localparam int BIT_CLKS = 16;   // 16 clk per bit on both instances

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic ce_a = 1'b1;
    logic ce_b = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic [2:0] st_a, st_b;

    logic       rx_sync_a, hb_a, bd_a, lb_a, valid_a, frame_err_a;
    logic [7:0] data_a;
    logic       rx_sync_b, hb_b, bd_b, lb_b, valid_b, frame_err_b;
    logic [7:0] data_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ce_div = 0;
    int strobe_no_ce = 0;
    int hb_b_seen = 0;

    int valid_n[2]   = '{0, 0};
    int ferr_n[2]    = '{0, 0};
    int bd_n[2]      = '{0, 0};
    int lb_n[2]      = '{0, 0};
    int lb_at[2]     = '{0, 0};
    int sc_n[2]      = '{0, 0};
    int valid_cyc[2] = '{0, 0};
    logic [7:0] got_byte[2]  = '{8'h00, 8'h00};
    logic [7:0] last_good[2] = '{8'h00, 8'h00};

    uart_rx_datapath #(.BAUD_DIV(16), .DATA_BITS(8)) dut_a (
        .clk(clk), .clr(clr), .ce(ce_a), .rx(rx_a), .status(st_a),
        .rx_sync(rx_sync_a), .hb(hb_a), .bd(bd_a), .lb(lb_a),
        .data(data_a), .valid(valid_a), .frame_err(frame_err_a)
    );

    uart_rx_datapath #(.BAUD_DIV(4), .DATA_BITS(8)) dut_b (
        .clk(clk), .clr(clr), .ce(ce_b), .rx(rx_b), .status(st_b),
        .rx_sync(rx_sync_b), .hb(hb_b), .bd(bd_b), .lb(lb_b),
        .data(data_b), .valid(valid_b), .frame_err(frame_err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behaviour of the uart_fsm peer that steps on the datapath strobes.
    function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic di,
                                            input logic h, input logic b, input logic l);
        case (s)
            ST_IDLE:        return di ? ST_IDLE : ST_START;
            ST_START:       return h ? ST_START_CHECK : ST_START;
            ST_START_CHECK: return di ? ST_IDLE : ST_READ;
            ST_READ:        return l ? ST_STOP : ST_READ;
            ST_STOP:        return b ? ST_IDLE : ST_STOP;
            default:        return ST_IDLE;
        endcase
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr)       st_a <= ST_IDLE;
        else if (ce_a) st_a <= fsm_next(st_a, rx_sync_a, hb_a, bd_a, lb_a);
    end

    always @(posedge clk or posedge clr) begin
        if (clr)       st_b <= ST_IDLE;
        else if (ce_b) st_b <= fsm_next(st_b, rx_sync_b, hb_b, bd_b, lb_b);
    end

    task automatic mon(input int i, input logic [2:0] st, input logic v, input logic fe,
                       input logic b, input logic l, input logic [7:0] d);
        if (v) begin
            valid_n[i]++;
            got_byte[i]  = d;
            valid_cyc[i] = cyc;
        end
        if (fe) ferr_n[i]++;
        if (b && st == ST_READ) bd_n[i]++;
        if (l) begin
            lb_n[i]++;
            lb_at[i] = bd_n[i];
        end
        if (st == ST_START_CHECK) sc_n[i]++;
    endtask

    always @(negedge clk) begin
        mon(0, st_a, valid_a, frame_err_a, bd_a, lb_a, data_a);
        mon(1, st_b, valid_b, frame_err_b, bd_b, lb_b, data_b);
        if ((hb_b | bd_b | lb_b) && !ce_b) strobe_no_ce++;
        if (hb_b) hb_b_seen++;
        ce_div = (ce_div + 1) % 4;
        ce_b   = (ce_div == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input int i, input logic v);
        if (i == 0) rx_a = v;
        else        rx_b = v;
    endtask

    task automatic send_frame(input int i, input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            set_rx(i, bits[k]);
            repeat (BIT_CLKS) @(negedge clk);
        end
        set_rx(i, 1'b1);
    endtask

    // Send one frame and compare what came out against the frame's own rules.
    task automatic run_frame(input int i, input logic [7:0] b, input logic stop);
        int v0, f0, bd0, lb0, t0;
        string nm;
        nm  = (i == 0) ? "a" : "b";
        @(negedge clk);
        v0  = valid_n[i];
        f0  = ferr_n[i];
        bd0 = bd_n[i];
        lb0 = lb_n[i];
        t0  = cyc;
        send_frame(i, b, stop);
        repeat (48 + $urandom_range(0, 20)) @(negedge clk);
        if (stop) last_good[i] = b;
        check({nm, "_valid_pulses"}, valid_n[i] - v0, stop ? 1 : 0);
        check({nm, "_ferr_pulses"}, ferr_n[i] - f0, stop ? 0 : 1);
        if (stop) check({nm, "_byte"}, got_byte[i], b);
        check({nm, "_data_held"}, (i == 0) ? data_a : data_b, last_good[i]);
        check({nm, "_bd_in_read"}, bd_n[i] - bd0, 8);
        check({nm, "_lb_pulses"}, lb_n[i] - lb0, 1);
        check({nm, "_lb_on_8th_bd"}, lb_at[i] - bd0, 8);
        if (i == 0 && stop)
            check("a_valid_latency", (valid_cyc[0] - t0) <= 10 * BIT_CLKS + 4, 1);
    endtask

    int v0, f0, sc0, bd0;

    initial begin
        // Reset asserted between clock edges: outputs must settle with no edge.
        #2 clr = 1'b1;
        #1;
        check("rst_rx_sync", rx_sync_a, 1);
        check("rst_data", data_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_frame_err", frame_err_a, 0);
        check("rst_strobes", {hb_a, bd_a, lb_a}, 0);
        check("rst_data_b", data_b, 0);
        repeat (3) @(negedge clk);
        clr = 1'b0;
        repeat (40) @(negedge clk);

        run_frame(0, 8'h90, 1'b1);

        // Short low glitch: false start, nothing may come out.
        @(negedge clk);
        v0 = valid_n[0]; f0 = ferr_n[0]; sc0 = sc_n[0]; bd0 = bd_n[0];
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (48) @(negedge clk);
        check("glitch_start_check", sc_n[0] - sc0, 1);
        check("glitch_valid", valid_n[0] - v0, 0);
        check("glitch_ferr", ferr_n[0] - f0, 0);
        check("glitch_bd", bd_n[0] - bd0, 0);
        check("glitch_data", data_a, last_good[0]);

        run_frame(0, 8'h45, 1'b0);
        for (int n = 0; n < 4; n++)
            run_frame(0, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));

        // Slow instance: ce one clock in four.
        run_frame(1, 8'h3C, 1'b1);
        for (int n = 0; n < 3; n++)
            run_frame(1, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
        check("b_strobe_without_ce", strobe_no_ce, 0);
        check("b_hb_seen", hb_b_seen > 0, 1);

        // Abort a frame with clr while the line is low mid data bits.
        @(negedge clk);
        v0 = valid_n[0]; f0 = ferr_n[0];
        rx_a = 1'b0;
        repeat (BIT_CLKS * 3 + 8) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("abort_rx_sync", rx_sync_a, 1);
        check("abort_data", data_a, 0);
        check("abort_strobes", {hb_a, bd_a, lb_a, valid_a, frame_err_a}, 0);
        rx_a = 1'b1;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        repeat (64) @(negedge clk);
        check("abort_valid", valid_n[0] - v0, 0);
        check("abort_ferr", ferr_n[0] - f0, 0);
        check("abort_data_after", data_a, last_good[0]);
        run_frame(0, 8'hA5, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
